// File: rtl/keccak_round_ctrl.sv
// Load/round/unload sequencer for the port-serial Keccak-f[200] core.
// Optional abort input: define KECCAK_CTRL_ABORT_EN to add abort_i.
//
// state  | meaning
// IDLE   | waiting for start_i
// LOAD   | accepting LANES input lanes
// ROUND  | ROUNDS round-update cycles, iota constant driven
// UNLOAD | returning LANES output lanes

module keccak_round_ctrl #(
    parameter int W      = 8,
    parameter int ROUNDS = 18,
    parameter int LANES  = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
`ifdef KECCAK_CTRL_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic         load_en_o,
    output logic         round_en_o,
    output logic [W-1:0] IotaRCI_o,
    output logic [4:0]   round_idx_o,
    output logic [4:0]   lane_idx_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         unload_en_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROUND  = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    localparam int RW = (W > 8) ? W : 8;
    localparam logic [4:0] LAST_LANE  = 5'(LANES - 1);
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    state_t     state, state_nxt;
    logic [4:0] lane_idx, lane_nxt;
    logic [4:0] round_idx, round_nxt;
    logic       done, done_nxt;
    logic       abort;
    logic [7:0] rc8;
    logic [RW-1:0] rc_ext;

`ifdef KECCAK_CTRL_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lane_idx  <= '0;
            round_idx <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            lane_idx  <= lane_nxt;
            round_idx <= round_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lane_nxt    = lane_idx;
        round_nxt   = round_idx;
        done_nxt    = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        round_en_o  = 1'b0;
        load_en_o   = 1'b0;
        unload_en_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = LOAD;
                    lane_nxt  = '0;
                    round_nxt = '0;
                end
            end
            LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i && !abort) begin
                    load_en_o = 1'b1;
                    if (lane_idx == LAST_LANE) begin
                        state_nxt = ROUND;
                        lane_nxt  = '0;
                        round_nxt = '0;
                    end else begin
                        lane_nxt = lane_idx + 5'd1;
                    end
                end
            end
            ROUND: begin
                round_en_o = 1'b1;
                if (round_idx == LAST_ROUND) begin
                    state_nxt = UNLOAD;
                    round_nxt = '0;
                    lane_nxt  = '0;
                end else begin
                    round_nxt = round_idx + 5'd1;
                end
            end
            UNLOAD: begin
                out_valid_o = 1'b1;
                if (out_ready_i && !abort) begin
                    unload_en_o = 1'b1;
                    if (lane_idx == LAST_LANE) begin
                        state_nxt = IDLE;
                        lane_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        lane_nxt = lane_idx + 5'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // abort wins over any handshake taken in the same cycle
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            lane_nxt  = '0;
            round_nxt = '0;
            done_nxt  = 1'b0;
        end
    end

    // Low byte of the Keccak-f round constants, rounds 0..17
    always_comb begin
        rc8 = 8'h00;
        case (round_idx)
            5'd0:  rc8 = 8'h01;
            5'd1:  rc8 = 8'h82;
            5'd2:  rc8 = 8'h8A;
            5'd3:  rc8 = 8'h00;
            5'd4:  rc8 = 8'h8B;
            5'd5:  rc8 = 8'h01;
            5'd6:  rc8 = 8'h81;
            5'd7:  rc8 = 8'h09;
            5'd8:  rc8 = 8'h8A;
            5'd9:  rc8 = 8'h88;
            5'd10: rc8 = 8'h09;
            5'd11: rc8 = 8'h0A;
            5'd12: rc8 = 8'h8B;
            5'd13: rc8 = 8'h8B;
            5'd14: rc8 = 8'h89;
            5'd15: rc8 = 8'h03;
            5'd16: rc8 = 8'h02;
            5'd17: rc8 = 8'h80;
            default: rc8 = 8'h00;
        endcase
    end

    assign rc_ext      = RW'(rc8);
    assign IotaRCI_o   = (state == ROUND) ? rc_ext[W-1:0] : '0;
    assign round_idx_o = round_idx;
    assign lane_idx_o  = lane_idx;
    assign busy_o      = (state != IDLE);
    assign done_o      = done;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Table-driven bench for keccak_round_ctrl with a latency scoreboard.
// Abort scenario is exercised only when KECCAK_CTRL_ABORT_EN is defined.

module tb_keccak_round_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_i = 1'b0;
`ifdef KECCAK_CTRL_ABORT_EN
    logic         abort_i = 1'b0;
`endif
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic         load_en_o;
    logic         round_en_o;
    logic [W-1:0] IotaRCI_o;
    logic [4:0]   round_idx_o;
    logic [4:0]   lane_idx_o;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic         unload_en_o;
    logic         busy_o;
    logic         done_o;

    keccak_round_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
`ifdef KECCAK_CTRL_ABORT_EN
        .abort_i     (abort_i),
`endif
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .load_en_o   (load_en_o),
        .round_en_o  (round_en_o),
        .IotaRCI_o   (IotaRCI_o),
        .round_idx_o (round_idx_o),
        .lane_idx_o  (lane_idx_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .unload_en_o (unload_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit toggle;
        int stall_lane;
        int stall_len;
        bit b2b;
        int exp_lat;
        int exp_ready;
        int exp_valid;
    } vec_t;

    int   rc_tab [18] = '{8'h01, 8'h82, 8'h8A, 8'h00, 8'h8B, 8'h01, 8'h81, 8'h09, 8'h8A,
                          8'h88, 8'h09, 8'h0A, 8'h8B, 8'h8B, 8'h89, 8'h03, 8'h02, 8'h80};
    vec_t vecs [5];
    int   exp_q [$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int any_out();
        return int'(|{in_ready_o, load_en_o, round_en_o, IotaRCI_o, round_idx_o,
                      lane_idx_o, out_valid_o, unload_en_o, busy_o, done_o});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int  loads = 0, rounds = 0, unloads = 0;
        int  n_ready = 0, n_valid = 0, n_round = 0;
        int  stall_left = v.stall_len;
        bit  seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start_i    = (k == 0) || (v.b2b && k == v.exp_lat);
            in_valid_i = v.toggle ? (k % 2 == 1) : 1'b1;
            if (out_valid_o && unloads == v.stall_lane && stall_left > 0) begin
                out_ready_i = 1'b0;
                stall_left--;
            end else begin
                out_ready_i = 1'b1;
            end
            if (k == 0) exp_q.push_back(v.exp_lat);
            #1;
            if (k == 0) chk("idle_busy", busy_o, 0);
            chk("ready_valid_excl", int'(in_ready_o & out_valid_o), 0);
            chk("load_en", load_en_o, int'(in_valid_i & in_ready_o));
            chk("unload_en", unload_en_o, int'(out_valid_o & out_ready_i));
            if (in_ready_o) begin
                n_ready++;
                chk("load_lane", lane_idx_o, loads);
            end
            if (out_valid_o) begin
                n_valid++;
                chk("unload_lane", lane_idx_o, unloads);
            end
            if (round_en_o) begin
                n_round++;
                if (rounds < 18) chk("iota", IotaRCI_o, rc_tab[rounds]);
                chk("round_idx", round_idx_o, rounds);
                rounds++;
            end else begin
                chk("iota_zero", IotaRCI_o, 0);
            end
            if (load_en_o) loads++;
            if (unload_en_o) unloads++;
            if (k > 0 && done_o) begin
                chk("latency", k, exp_q.pop_front());
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            void'(exp_q.pop_front());
        end
        chk("in_ready_cycles", n_ready, v.exp_ready);
        chk("load_beats", loads, 25);
        chk("round_cycles", n_round, 18);
        chk("out_valid_cycles", n_valid, v.exp_valid);
        chk("unload_beats", unloads, 25);
        @(negedge clk);
        start_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("done_single", done_o, 0);
        if (v.b2b) begin
            chk("b2b_busy", busy_o, 1);
            chk("b2b_in_ready", in_ready_o, 1);
            chk("b2b_lane", lane_idx_o, 0);
            do_reset();
        end else begin
            chk("post_busy", busy_o, 0);
        end
        if (id < 0) $display("unreachable");
    endtask

    initial begin
        bit hit;
        vecs[0] = '{toggle: 1'b0, stall_lane: 0,  stall_len: 0,  b2b: 1'b0, exp_lat: 69, exp_ready: 25, exp_valid: 25};
        vecs[1] = '{toggle: 1'b1, stall_lane: 0,  stall_len: 0,  b2b: 1'b0, exp_lat: 93, exp_ready: 49, exp_valid: 25};
        vecs[2] = '{toggle: 1'b0, stall_lane: 12, stall_len: 10, b2b: 1'b0, exp_lat: 79, exp_ready: 25, exp_valid: 35};
        vecs[3] = '{toggle: 1'b1, stall_lane: 0,  stall_len: 5,  b2b: 1'b0, exp_lat: 98, exp_ready: 49, exp_valid: 30};
        vecs[4] = '{toggle: 1'b0, stall_lane: 0,  stall_len: 0,  b2b: 1'b1, exp_lat: 69, exp_ready: 25, exp_valid: 25};

        #2 rst = 1'b1;
        #2;
        chk("reset_outputs", any_out(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_reset_outputs", any_out(), 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // asynchronous reset in the middle of round 7
        @(negedge clk);
        start_i = 1'b1;
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            chk("no_done_before_rst", done_o, 0);
            if (round_en_o && round_idx_o == 5'd7) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reached_round7", hit, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", any_out(), 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_no_done", done_o, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_idle", any_out(), 0);
        run_vec(vecs[0], 5);

`ifdef KECCAK_CTRL_ABORT_EN
        @(negedge clk);
        start_i = 1'b1;
        in_valid_i = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            if (in_ready_o && lane_idx_o == 5'd10) begin
                abort_i = 1'b1;
                #1;
                chk("abort_load_en", load_en_o, 0);
                hit = 1'b1;
                break;
            end
        end
        chk("reached_lane10", hit, 1);
        @(negedge clk);
        start_i = 1'b1;
        #1;
        chk("abort_idle_busy", busy_o, 0);
        chk("abort_no_done", done_o, 0);
        chk("abort_idle_ready", in_ready_o, 0);
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("start_with_abort_idle", in_ready_o, 1);
        chk("start_with_abort_lane", lane_idx_o, 0);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
Sequencer for the round-based, port-serial Keccak-f[200] core. It runs each permutation in three phases:
- load: 25 W-bit lanes accepted over a valid/ready port
- round: ROUNDS consecutive round-update cycles; the controller supplies the iota round constant to the chi/iota stage
- unload: 25 lanes returned over a valid/ready port

It drives the state-register enables and mux selects. It contains no state datapath itself.

Parameters:
W, 8, lane width in bits; also the width of the round constant driven to the chi/iota stage
ROUNDS, 18, rounds per permutation; must be 1..18
LANES, 25, lanes per state; fixes the load and unload beat counts

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
start_i  in  1  request a permutation; sampled only in IDLE
in_valid_i  in  1  producer has a lane on the input port
in_ready_o  out  1  controller accepts a lane this cycle
load_en_o  out  1  shift the input lane into the state register; = in_valid_i & in_ready_o
round_en_o  out  1  capture the round-function output into the state register
IotaRCI_o  out  W  round constant for the current round; zero outside ROUND
round_idx_o  out  5  current round number, 0..ROUNDS-1
lane_idx_o  out  5  current lane number within LOAD/UNLOAD, 0..LANES-1
out_valid_o  out  1  lane on the output port is valid
out_ready_i  in  1  consumer takes the output lane
unload_en_o  out  1  shift the state register out by one lane; = out_valid_o & out_ready_i
busy_o  out  1  high in any state except IDLE
done_o  out  1  single-cycle pulse when the permutation completes

Behaviour:
- States: IDLE, LOAD, ROUND, UNLOAD, encoded in 2 bits.
- Reset (asynchronous, any time including mid-operation):
  - state goes to IDLE; all counters go to 0
  - every output is 0: in_ready, load_en, round_en, IotaRCI, round_idx, lane_idx, out_valid, unload_en, busy, done
  - no partial result is flagged
- IDLE:
  - start_i=1 moves to LOAD next cycle with lane_idx=0
  - start_i is ignored in every other state
- LOAD:
  - in_ready_o=1
  - each cycle with in_valid_i=1 is one beat: lane_idx increments
  - the beat taken at lane_idx=LANES-1 moves to ROUND with round_idx=0 and lane_idx=0
  - in_valid_i=0 stalls the phase: no counter change
- ROUND:
  - round_en_o=1 every cycle
  - IotaRCI_o = RC[round_idx], taken from a constant table of the low 8 bits of the Keccak RCs: 01,82,8A,00,8B,01,81,09,8A,88,09,0A,8B,8B,89,03,02,80 (hex, rounds 0..17)
  - for W<8, IotaRCI_o is the low W bits of the table entry
  - round_idx increments each cycle; at round_idx=ROUNDS-1 the state moves to UNLOAD next cycle
  - the phase lasts exactly ROUNDS cycles and never stalls
- UNLOAD:
  - out_valid_o=1
  - each cycle with out_ready_i=1 is one beat: lane_idx increments
  - the beat at lane_idx=LANES-1 moves to IDLE and asserts done_o for exactly the next cycle, which is the first IDLE cycle
  - out_ready_i=0 holds the phase
- Outputs:
  - IotaRCI_o, round_en_o, in_ready_o and out_valid_o are decoded combinationally from the registered state and counters
  - done_o is registered
- Minimum latency, start accepted to done_o high: 1 + LANES + ROUNDS + LANES = 69 cycles with defaults, with input always valid and output always ready.
- Back-to-back use: start_i asserted in the done_o cycle is accepted and enters LOAD on the next cycle.
- Simultaneous events:
  - in_valid_i or out_ready_i asserted outside its own phase is ignored
  - in_ready_o and out_valid_o are never high together

Optional Feature:
KECCAK_CTRL_ABORT_EN:
- Defined: adds input port abort_i (1 bit).
  - abort_i=1 in LOAD, ROUND or UNLOAD: next cycle state=IDLE, counters=0, done_o stays 0.
  - abort_i has priority over any beat handshake in the same cycle; that beat's load_en_o/unload_en_o is forced to 0.
  - abort_i in IDLE has no effect and does not block start_i.
- Not defined: port absent; a permutation can be interrupted only by rst.

Test Plan:
- Reset, then start_i pulse, in_valid constant 1, out_ready constant 1 -> in_ready high 25 cycles, round_en high 18 cycles, out_valid high 25 cycles; done_o high exactly at cycle 69 after start; busy low afterwards.
- Round-constant check during ROUND -> IotaRCI_o sequence 01,82,8A,00,8B,01,81,09,8A,88,09,0A,8B,8B,89,03,02,80; IotaRCI_o=00 in all other states.
- in_valid toggled 1,0,1,0… during LOAD -> 25 load_en pulses over 49 cycles; lane_idx advances only on beats; ROUND starts right after the 25th beat.
- out_ready held 0 for 10 cycles at lane 12 of UNLOAD -> out_valid stays 1, lane_idx stays 12, no unload_en; completion is delayed by 10 cycles.
- rst asserted asynchronously at round 7 -> outputs zero immediately (without waiting for a clock edge), no done_o; a new start runs a clean 69-cycle permutation.
- KECCAK_CTRL_ABORT_EN defined, abort_i at LOAD beat 10 together with in_valid -> load_en=0 that cycle, IDLE next cycle, no done_o; start_i in the same cycle as abort_i in IDLE is accepted.
